// File: rtl/letc_core_pkg.sv
// letc_core_pkg: shared register-index type for the LETC core
package letc_core_pkg;
  typedef logic [4:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/letc_core_scoreboard_queue.sv
// letc_core_scoreboard_queue: circular rd queue with push, pop and discard-N
module letc_core_scoreboard_queue
  import letc_core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  reg_idx_t             push_rd_i,
  input  logic                 pop_i,
  input  logic [CW-1:0]        discard_i,
  output logic [DEPTH-1:0]     ent_valid_o,
  output reg_idx_t [DEPTH-1:0] ent_rd_o,
  output reg_idx_t             head_rd_o,
  output logic [CW-1:0]        occ_o
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d, after_pop, drop;
  reg_idx_t [DEPTH-1:0] rd_q;
  // pop is applied before the discard, and the discard is clamped to what is left
  always_comb begin
    after_pop = occ_q - CW'(pop_i);
    drop = discard_i > after_pop ? after_pop : discard_i;
    head_d = head_q + PW'(pop_i);
    tail_d = tail_q + PW'(push_i) - PW'(drop);
    occ_d = after_pop + CW'(push_i) - drop;
  end
  always_comb begin
    ent_valid_o = '0;
    for (int i = 0; i < DEPTH; i++)
      ent_valid_o[i] = {1'b0, PW'(PW'(i) - head_q)} < occ_q;
  end
  assign ent_rd_o = rd_q;
  assign head_rd_o = rd_q[head_q];
  assign occ_o = occ_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
      rd_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      if (push_i) rd_q[tail_q] <= push_rd_i;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (discard_i <= after_pop);
      assert (!(push_i && occ_q == CW'(DEPTH)));
    end
  end
`endif
endmodule

// File: rtl/letc_core_stage_d_scoreboard.sv
// letc_core_stage_d_scoreboard: decode-stage RAW/full hazard scheduler over an in-order rd queue
module letc_core_stage_d_scoreboard
  import letc_core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_d_valid,
  input  logic          i_d_rs1_used,
  input  reg_idx_t      i_d_rs1_idx,
  input  logic          i_d_rs2_used,
  input  reg_idx_t      i_d_rs2_idx,
  input  logic          i_d_rd_we,
  input  reg_idx_t      i_d_rd_idx,
  output logic          o_d_stall,
  output logic          o_d_issue,
  input  logic          i_wb_valid,
  input  reg_idx_t      i_wb_rd_idx,
  input  logic          i_flush,
  input  logic [CW-1:0] i_flush_count,
  output logic [CW-1:0] o_occupancy,
  output logic          o_empty,
  output logic          o_full
);
  logic [DEPTH-1:0] ent_valid;
  reg_idx_t [DEPTH-1:0] ent_rd;
  reg_idx_t head_rd;
  logic pend1, pend2, push_needed, pop;
  letc_core_scoreboard_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .push_i(o_d_issue & push_needed),
    .push_rd_i(i_d_rd_idx),
    .pop_i(pop),
    .discard_i(i_flush ? i_flush_count : '0),
    .ent_valid_o(ent_valid),
    .ent_rd_o(ent_rd),
    .head_rd_o(head_rd),
    .occ_o(o_occupancy)
  );
  // registered state only: a same-cycle writeback does not clear a hazard
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend1 |= ent_valid[i] & (ent_rd[i] == i_d_rs1_idx);
      pend2 |= ent_valid[i] & (ent_rd[i] == i_d_rs2_idx);
    end
    pend1 &= i_d_rs1_idx != REG_ZERO;
    pend2 &= i_d_rs2_idx != REG_ZERO;
  end
  assign push_needed = i_d_rd_we & (i_d_rd_idx != REG_ZERO);
  assign o_empty = o_occupancy == '0;
  assign o_full = o_occupancy == CW'(DEPTH);
  assign pop = i_wb_valid & ~o_empty;
  assign o_d_stall = i_d_valid & ((i_d_rs1_used & pend1) | (i_d_rs2_used & pend2) | (push_needed & o_full));
  assign o_d_issue = i_d_valid & ~o_d_stall & ~i_flush;
`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_wb_valid) begin
      assert (!o_empty);
      if (!o_empty) assert (i_wb_rd_idx == head_rd);
    end
  end
`endif
endmodule

// File: tb/tb_letc_core_stage_d_scoreboard.sv
// tb_letc_core_stage_d_scoreboard: directed + random stimulus against a queue reference model
module tb_letc_core_stage_d_scoreboard;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, d_valid, rs1_used, rs2_used, rd_we, wb_valid, flush;
  logic [4:0] rs1_idx, rs2_idx, rd_idx, wb_rd_idx;
  logic [2:0] flush_count, occupancy;
  logic d_stall, d_issue, empty, full;
  typedef struct {
    logic stall;
    logic issue;
    int   occ;
  } exp_t;
  exp_t exq[$];
  int mq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_ret = 0;

  letc_core_stage_d_scoreboard #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_d_valid(d_valid),
    .i_d_rs1_used(rs1_used), .i_d_rs1_idx(rs1_idx),
    .i_d_rs2_used(rs2_used), .i_d_rs2_idx(rs2_idx),
    .i_d_rd_we(rd_we), .i_d_rd_idx(rd_idx),
    .o_d_stall(d_stall), .o_d_issue(d_issue),
    .i_wb_valid(wb_valid), .i_wb_rd_idx(wb_rd_idx),
    .i_flush(flush), .i_flush_count(flush_count),
    .o_occupancy(occupancy), .o_empty(empty), .o_full(full)
  );

  always #5 clk = ~clk;

  function automatic bit pending(int r);
    if (r == 0) return 0;
    foreach (mq[k]) if (mq[k] == r) return 1;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exq.size() > 0) begin
      e = exq.pop_front();
      chk("stall", int'(d_stall), int'(e.stall));
      chk("issue", int'(d_issue), int'(e.issue));
      chk("occupancy", int'(occupancy), e.occ);
      chk("empty", int'(empty), int'(e.occ == 0));
      chk("full", int'(full), int'(e.occ == DEPTH));
    end
  end

  task automatic step(input bit v, input bit u1, input int r1, input bit u2, input int r2,
                      input bit we, input int rd, input bit wb, input int wbrd,
                      input bit fl, input int fc, input bit rs);
    bit stl, iss, pn;
    exp_t e;
    rst = rs; d_valid = v; rs1_used = u1; rs1_idx = 5'(r1); rs2_used = u2; rs2_idx = 5'(r2);
    rd_we = we; rd_idx = 5'(rd); wb_valid = wb; wb_rd_idx = 5'(wbrd);
    flush = fl; flush_count = 3'(fc);
    pn = we && rd != 0;
    stl = v && ((u1 && pending(r1)) || (u2 && pending(r2)) || (pn && mq.size() == DEPTH));
    iss = v && !stl && !fl;
    e.stall = stl; e.issue = iss; e.occ = mq.size();
    exq.push_back(e);
    @(posedge clk);
    #1;
    if (rs) mq.delete();
    else begin
      if (wb && mq.size() > 0) last_ret = mq.pop_front();
      if (iss && pn) mq.push_back(rd);
      if (fl) for (int k = 0; k < fc && mq.size() > 0; k++) void'(mq.pop_back());
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writer(input int rd);
    step(1, 0, 0, 0, 0, 1, rd, 0, 0, 0, 0, 0);
  endtask

  task automatic retire();
    step(0, 0, 0, 0, 0, 0, 0, 1, mq[0], 0, 0, 0);
  endtask

  task automatic rand_step();
    bit wb, fl;
    int fc;
    wb = mq.size() > 0 && $urandom_range(0, 1) == 1;
    fl = $urandom_range(0, 9) == 0;
    fc = $urandom_range(0, mq.size() - int'(wb));
    step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
         $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2) != 0,
         $urandom_range(0, 7), wb, wb ? mq[0] : 0, fl, fc, $urandom_range(0, 63) == 0);
  endtask

  initial begin
    rst = 1; d_valid = 0; rs1_used = 0; rs1_idx = 0; rs2_used = 0; rs2_idx = 0;
    rd_we = 0; rd_idx = 0; wb_valid = 0; wb_rd_idx = 0; flush = 0; flush_count = 0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    // RAW on a just-issued writer, cleared only the cycle after writeback
    step(1, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 0);
    step(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    // x0 is never tracked
    writer(0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // full stalls even with a same-cycle retire
    for (int r = 1; r <= 4; r++) writer(r);
    step(1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    writer(5);
    idle();
    while (mq.size() > 0) retire();
    // retire and flush in one cycle, issue suppressed
    for (int r = 1; r <= 3; r++) writer(r);
    step(1, 0, 0, 0, 0, 1, 6, 1, 1, 1, 2, 0);
    idle();
    // wrap the pointers with push/retire pairs
    for (int r = 7; r <= 9; r++) writer(r);
    last_ret = 0;
    for (int k = 0; k < 6; k++) step(1, 1, last_ret, 0, 0, 1, 10 + k, 1, mq[0], 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 1, mq[k], 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (mq.size() > 0) retire();
    // reset mid-stream drops a pending hazard
    writer(11);
    writer(12);
    step(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) rand_step();
    idle();
    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
